// File: rtl/blit_pkg.sv
// Shared types and widths for the blitter SDRAM responder.
package blit_pkg;

   localparam int unsigned BLIT_ADDR_W = 26;
   localparam int unsigned BLIT_DATA_W = 32;

   typedef enum logic [1:0] {
      IDLE,
      RD_CMD,
      RD_DATA,
      WR
   } blit_resp_state_t;

endpackage

// File: rtl/blit_sdram_responder.sv
// Blitter-side SDRAM endpoint: round-robin between the read and write ports,
// issuing burst reads and single-word writes on one controller channel.
module blit_sdram_responder
   import blit_pkg::*;
#(
   parameter int unsigned BURST_WORDS   = 8,
   parameter int unsigned MAX_WRITE_RUN = 16
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   blitr_sdram_request,
   input  logic [BLIT_ADDR_W-1:0] blitr_sdram_address,
   output logic                   blitr_sdram_ready,
   output logic                   blitr_sdram_rvalid,
   output logic [BLIT_DATA_W-1:0] blitr_sdram_rdata,
   output logic [BLIT_ADDR_W-1:0] blitr_sdram_raddress,
   output logic                   blitr_sdram_complete,
   input  logic                   blitw_sdram_request,
   output logic                   blitw_sdram_ready,
   input  logic [BLIT_ADDR_W-1:0] blitw_sdram_address,
   input  logic [3:0]             blitw_sdram_wstrb,
   input  logic [BLIT_DATA_W-1:0] blitw_sdram_wdata,
   output logic                   sdram_cmd_valid,
   input  logic                   sdram_cmd_ready,
   output logic                   sdram_cmd_write,
   output logic [BLIT_ADDR_W-1:0] sdram_cmd_address,
   output logic [3:0]             sdram_cmd_wstrb,
   output logic [BLIT_DATA_W-1:0] sdram_cmd_wdata,
   input  logic                   sdram_rsp_valid,
   input  logic [BLIT_DATA_W-1:0] sdram_rsp_data
);

   localparam int unsigned OFS_W  = $clog2(BURST_WORDS * 4);
   localparam int unsigned BEAT_W = $clog2(BURST_WORDS);
   localparam int unsigned RUN_W  = $clog2(MAX_WRITE_RUN + 1);
   localparam logic [BLIT_ADDR_W-1:0] OFS_MASK  = BLIT_ADDR_W'((32'd1 << OFS_W) - 32'd1);
   localparam logic [BEAT_W-1:0]      LAST_BEAT = BEAT_W'(BURST_WORDS - 1);
   localparam logic [RUN_W-1:0]       RUN_MAX   = RUN_W'(MAX_WRITE_RUN);

   blit_resp_state_t       state_q, state_d;
   logic [BLIT_ADDR_W-1:0] base_q, base_d;
   logic [BEAT_W-1:0]      beat_q, beat_d;
   logic [RUN_W-1:0]       wrun_q, wrun_d;
   logic                   last_served_q, last_served_d;
   logic                   rready_q, rready_d;
   logic                   rvalid_q, rvalid_d;
   logic [BLIT_DATA_W-1:0] rdata_q, rdata_d;
   logic [BLIT_ADDR_W-1:0] raddr_q, raddr_d;
   logic                   complete_q, complete_d;

   always_comb begin
      state_d           = state_q;
      base_d            = base_q;
      beat_d            = beat_q;
      wrun_d            = wrun_q;
      last_served_d     = last_served_q;
      rready_d          = 1'b0;
      rvalid_d          = 1'b0;
      rdata_d           = rdata_q;
      raddr_d           = raddr_q;
      complete_d        = 1'b0;
      sdram_cmd_valid   = 1'b0;
      sdram_cmd_write   = 1'b0;
      sdram_cmd_address = '0;
      sdram_cmd_wstrb   = '0;
      sdram_cmd_wdata   = '0;
      blitw_sdram_ready = 1'b0;

      case (state_q)
         IDLE: begin
            // last_served_q = 1 means the write port went last, so a read wins a tie
            if (blitr_sdram_request && (!blitw_sdram_request || last_served_q)) begin
               state_d = RD_CMD;
               base_d  = blitr_sdram_address & ~OFS_MASK;
            end else if (blitw_sdram_request) begin
               state_d = WR;
               wrun_d  = '0;
            end
         end
         RD_CMD: begin
            sdram_cmd_valid   = 1'b1;
            sdram_cmd_address = base_q;
            if (sdram_cmd_ready) begin
               rready_d = 1'b1;
               beat_d   = '0;
               state_d  = RD_DATA;
            end
         end
         RD_DATA: begin
            if (sdram_rsp_valid) begin
               rvalid_d   = 1'b1;
               rdata_d    = sdram_rsp_data;
               raddr_d    = base_q + BLIT_ADDR_W'({beat_q, 2'b00});
               complete_d = (beat_q == LAST_BEAT);
               beat_d     = beat_q + BEAT_W'(1);
               if (beat_q == LAST_BEAT) begin
                  last_served_d = 1'b0;
                  state_d       = IDLE;
               end
            end
         end
         WR: begin
            sdram_cmd_valid   = blitw_sdram_request;
            sdram_cmd_write   = 1'b1;
            sdram_cmd_address = blitw_sdram_address;
            sdram_cmd_wstrb   = blitw_sdram_wstrb;
            sdram_cmd_wdata   = blitw_sdram_wdata;
            blitw_sdram_ready = blitw_sdram_request & sdram_cmd_ready;
            if (blitw_sdram_ready && wrun_q != RUN_MAX) begin
               wrun_d = wrun_q + RUN_W'(1);
            end
            // Test the post-increment count so the word that fills the run is the last one
            if (!blitw_sdram_request || (wrun_d == RUN_MAX && blitr_sdram_request)) begin
               state_d       = IDLE;
               last_served_d = 1'b1;
               wrun_d        = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q       <= IDLE;
         base_q        <= '0;
         beat_q        <= '0;
         wrun_q        <= '0;
         last_served_q <= 1'b0;
         rready_q      <= 1'b0;
         rvalid_q      <= 1'b0;
         rdata_q       <= '0;
         raddr_q       <= '0;
         complete_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         base_q        <= base_d;
         beat_q        <= beat_d;
         wrun_q        <= wrun_d;
         last_served_q <= last_served_d;
         rready_q      <= rready_d;
         rvalid_q      <= rvalid_d;
         rdata_q       <= rdata_d;
         raddr_q       <= raddr_d;
         complete_q    <= complete_d;
      end
   end

   assign blitr_sdram_ready    = rready_q;
   assign blitr_sdram_rvalid   = rvalid_q;
   assign blitr_sdram_rdata    = rdata_q;
   assign blitr_sdram_raddress = raddr_q;
   assign blitr_sdram_complete = complete_q;

   always_ff @(posedge clock) begin
      if (reset && sdram_rsp_valid) begin
         assert (state_q == RD_DATA)
            else $warning("sdram_rsp_valid outside a read burst is ignored");
      end
   end

endmodule
